// File: rtl/bpred_table_ctrl.sv
// Branch prediction table controller: a table of 2-bit predictors, an in-flight FIFO
// that pairs in-order resolutions with their lookups, and saturating statistics.
module bpred_table_ctrl #(
   parameter int IDX_W = 4,
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     lk_valid,
   input  logic [IDX_W-1:0]         lk_idx,
   output logic                     lk_ready,
   output logic                     pred_valid,
   output logic                     pred_taken,
   input  logic                     rs_valid,
   input  logic                     rs_taken,
   output logic                     mispredict,
   output logic                     rs_err,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   inflight,
   output logic [CNT_W-1:0]         cnt_resolved,
   output logic [CNT_W-1:0]         cnt_mispred
);

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int OCC_W   = PTR_W + 1;
   localparam int ENTRIES = 1 << IDX_W;

   typedef enum logic [1:0] {
      ST_A = 2'b00,   // strong taken
      ST_B = 2'b01,   // weak taken
      ST_C = 2'b10,   // strong not-taken
      ST_D = 2'b11    // weak not-taken
   } bp_state_t;

   function automatic bp_state_t next_state(input bp_state_t s, input logic taken);
      bp_state_t n;
      case (s)
         ST_A:    n = taken ? ST_A : ST_B;
         ST_B:    n = taken ? ST_A : ST_C;
         ST_C:    n = taken ? ST_D : ST_C;
         ST_D:    n = taken ? ST_A : ST_C;
         default: n = ST_A;
      endcase
      return n;
   endfunction

   function automatic logic predict(input bp_state_t s);
      return (s == ST_A) || (s == ST_B);
   endfunction

   bp_state_t          table_r     [ENTRIES];
   logic [IDX_W-1:0]   fifo_idx_r  [DEPTH];
   logic               fifo_pred_r [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_r;
   logic [PTR_W-1:0]   rd_ptr_r;
   logic [OCC_W-1:0]   count_r;

   logic               full_s;
   logic               empty_s;
   logic               push_s;
   logic               pop_s;
   logic               lk_pred_s;
   logic [IDX_W-1:0]   head_idx_s;
   logic               head_pred_s;
   logic               miss_s;

   assign full_s      = (count_r == OCC_W'(DEPTH));
   assign empty_s     = (count_r == {OCC_W{1'b0}});
   assign lk_ready    = !full_s && !flush;
   assign push_s      = lk_valid && lk_ready;
   assign pop_s       = rs_valid && !empty_s && !flush;
   // Table read happens before this cycle's resolution write lands.
   assign lk_pred_s   = predict(table_r[lk_idx]);
   assign head_idx_s  = fifo_idx_r[rd_ptr_r];
   assign head_pred_s = fifo_pred_r[rd_ptr_r];
   assign miss_s      = pop_s && (rs_taken != head_pred_s);
   assign inflight    = count_r;

   // In-flight FIFO storage, pointers and occupancy.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {OCC_W{1'b0}};
      end else begin
         if (push_s) begin
            fifo_idx_r[wr_ptr_r]  <= lk_idx;
            fifo_pred_r[wr_ptr_r] <= lk_pred_s;
            wr_ptr_r              <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + OCC_W'(1);
            2'b01:   count_r <= count_r - OCC_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Predictor table: reset to strong taken, trained by each applied resolution.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            table_r[i] <= ST_A;
         end
      end else if (pop_s) begin
         table_r[head_idx_s] <= next_state(table_r[head_idx_s], rs_taken);
      end
   end

   // Registered prediction, status pulses and saturating statistics.
   always_ff @(posedge clk) begin
      if (reset) begin
         pred_valid   <= 1'b0;
         pred_taken   <= 1'b0;
         mispredict   <= 1'b0;
         rs_err       <= 1'b0;
         cnt_resolved <= {CNT_W{1'b0}};
         cnt_mispred  <= {CNT_W{1'b0}};
      end else begin
         pred_valid <= push_s;
         if (push_s) begin
            pred_taken <= lk_pred_s;
         end
         mispredict <= miss_s;
         rs_err     <= rs_valid && empty_s && !flush;
         if (pop_s && (cnt_resolved != {CNT_W{1'b1}})) begin
            cnt_resolved <= cnt_resolved + CNT_W'(1);
         end
         if (miss_s && (cnt_mispred != {CNT_W{1'b1}})) begin
            cnt_mispred <= cnt_mispred + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_bpred_table_ctrl.sv
// Scoreboard bench for bpred_table_ctrl: directed scenarios then random traffic,
// checked against a queue/array model of the predictor table.
module tb_bpred_table_ctrl;

   localparam int IDX_W = 4;
   localparam int DEPTH = 4;
   localparam int CNT_W = 4;
   localparam int CMAX  = 15;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             lk_valid = 1'b0;
   logic [IDX_W-1:0] lk_idx = '0;
   logic             rs_valid = 1'b0;
   logic             rs_taken = 1'b0;
   logic             flush = 1'b0;
   logic             lk_ready, pred_valid, pred_taken, mispredict, rs_err;
   logic [2:0]       inflight;
   logic [CNT_W-1:0] cnt_resolved, cnt_mispred;

   bpred_table_ctrl #(.IDX_W(IDX_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .lk_valid(lk_valid), .lk_idx(lk_idx), .lk_ready(lk_ready),
      .pred_valid(pred_valid), .pred_taken(pred_taken), .rs_valid(rs_valid),
      .rs_taken(rs_taken), .mispredict(mispredict), .rs_err(rs_err), .flush(flush),
      .inflight(inflight), .cnt_resolved(cnt_resolved), .cnt_mispred(cnt_mispred)
   );

   always #5 clk = ~clk;

   typedef struct {int idx; bit pred;} inf_t;
   typedef struct {bit pv; bit pt; bit mp; bit err; int infl; int cr; int cm;} exp_t;

   inf_t mq[$];
   exp_t cyc_q[$];
   bit   pred_q[$];
   exp_t me;
   int   mtbl[16];
   int   m_cr, m_cm;
   bit   m_pt;
   int   checks = 0;
   int   passed = 0;
   // States 0..3 = A,B,C,D; successor on taken / not-taken.
   int   nxt_t[4] = '{0, 0, 3, 0};
   int   nxt_n[4] = '{1, 2, 2, 2};
   int   pat[4]   = '{0, 0, 1, 1};

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) mtbl[i] = 0;
      mq.delete();
      m_cr = 0;
      m_cm = 0;
      m_pt = 1'b0;
   endtask

   task automatic cycle(input bit lkv, input int idx, input bit rsv, input bit tk,
                        input bit fl, input bit rst);
      exp_t e;
      bit   acc, p;
      inf_t h;
      lk_valid = lkv; lk_idx = idx[IDX_W-1:0]; rs_valid = rsv; rs_taken = tk;
      flush = fl; reset = rst;
      acc = lkv && (mq.size() < DEPTH) && !fl;
      p   = 1'b0;
      #1 chk("lk_ready", int'(lk_ready), int'((mq.size() < DEPTH) && !fl));
      e = '{default: 0};
      if (rst) begin
         model_reset();
      end else begin
         if (acc) begin
            p = (mtbl[idx] < 2);
            pred_q.push_back(p);
            m_pt = p;
            e.pv = 1'b1;
         end
         if (fl) begin
            mq.delete();
         end else if (rsv) begin
            if (mq.size() == 0) begin
               e.err = 1'b1;
            end else begin
               h = mq.pop_front();
               mtbl[h.idx] = tk ? nxt_t[mtbl[h.idx]] : nxt_n[mtbl[h.idx]];
               m_cr = (m_cr == CMAX) ? CMAX : m_cr + 1;
               if (tk != h.pred) begin
                  e.mp = 1'b1;
                  m_cm = (m_cm == CMAX) ? CMAX : m_cm + 1;
               end
            end
         end
         if (acc) mq.push_back('{idx, p});
      end
      e.pt = m_pt; e.infl = mq.size(); e.cr = m_cr; e.cm = m_cm;
      @(posedge clk);
      #1 cyc_q.push_back(e);
   endtask

   // Monitor: compares what the DUT presents after each edge against the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (cyc_q.size() > 0) begin
            me = cyc_q.pop_front();
            chk("pred_valid", int'(pred_valid), int'(me.pv));
            if (pred_valid) begin
               if (pred_q.size() == 0) chk("pred_unexpected", 1, 0);
               else chk("pred_taken", int'(pred_taken), int'(pred_q.pop_front()));
            end else begin
               chk("pred_hold", int'(pred_taken), int'(me.pt));
            end
            chk("mispredict", int'(mispredict), int'(me.mp));
            chk("rs_err", int'(rs_err), int'(me.err));
            chk("inflight", int'(inflight), me.infl);
            chk("cnt_resolved", int'(cnt_resolved), me.cr);
            chk("cnt_mispred", int'(cnt_mispred), me.cm);
            chk("mispred_le_resolved", int'(cnt_mispred <= cnt_resolved), 1);
         end
      end
   end

   initial begin
      model_reset();
      @(posedge clk);
      #1;
      cycle(0, 0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 0, 1);
      // First lookup and a mispredicted resolution.
      cycle(1, 3, 0, 0, 0, 0);
      cycle(0, 0, 1, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0);
      // Walk entry 5 through A->B->C->D->A.
      for (int i = 0; i < 5; i++) begin
         cycle(1, 5, 0, 0, 0, 0);
         cycle(0, 0, 1, (i >= 2), 0, 0);
      end
      // Fill to DEPTH, refused fifth lookup, one pop reopens.
      for (int i = 0; i < 5; i++) cycle(1, i, 0, 0, 0, 0);
      cycle(0, 0, 1, 1, 0, 0);
      cycle(1, 2, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) cycle(0, 0, 1, 1, 0, 0);
      // Same-index lookup and resolve in one cycle.
      cycle(1, 7, 0, 0, 0, 0);
      cycle(1, 7, 1, 0, 0, 0);
      cycle(1, 7, 1, 1, 0, 0);
      cycle(0, 0, 1, 1, 0, 0);
      // Resolve on empty, then flush with three in flight.
      cycle(0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) cycle(1, 10 + i, 0, 0, 0, 0);
      cycle(1, 4, 1, 1, 1, 0);
      cycle(0, 0, 0, 0, 0, 0);
      // Repeated mispredictions on entry 9 to saturate the counters.
      for (int i = 0; i < 20; i++) begin
         cycle(1, 9, 0, 0, 0, 0);
         cycle(0, 0, 1, pat[i % 4], 0, 0);
      end
      // Reset mid-stream, then probe entries.
      cycle(1, 1, 0, 0, 0, 0);
      cycle(1, 9, 0, 0, 0, 0);
      cycle(0, 0, 1, 0, 0, 1);
      for (int i = 0; i < 16; i += 3) cycle(1, i, 1, 0, 0, 0);
      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         cycle($urandom_range(0, 1), $urandom_range(0, 15), ($urandom_range(0, 2) != 0),
               $urandom_range(0, 1), ($urandom_range(0, 31) == 0),
               ($urandom_range(0, 199) == 0));
      end
      cycle(0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      #1;
      chk("scoreboard_drained", cyc_q.size(), 0);
      chk("pred_queue_drained", pred_q.size(), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
